// File: rtl/rcb_spi_regs.sv
// rcb_spi_regs: SPI-facing register bank (ID, scratch, ctrl, status, cmd, counters).
// Optional watchdog on CTRL[31] built when RCB_REGS_WDOG_EN is defined.
module rcb_spi_regs #(
  parameter logic [31:0] FPGA_ID     = 32'h5243_4200,
  parameter logic [31:0] FPGA_VER    = 32'h0000_0100,
  parameter logic [31:0] WDOG_CYCLES = 32'd100_000_000
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        addr_rdy,
  input  logic [31:0] data_mosi,
  input  logic        data_mosi_rdy,
  output logic [31:0] data_miso,
  input  logic [15:0] status_in,
  input  logic [14:0] event_in,
  output logic [31:0] ctrl_out,
  output logic [31:0] cmd_pulse
);

  localparam logic [15:0] A_ID   = 16'h0000;
  localparam logic [15:0] A_VER  = 16'h0001;
  localparam logic [15:0] A_SCR  = 16'h0002;
  localparam logic [15:0] A_CTRL = 16'h0003;
  localparam logic [15:0] A_STAT = 16'h0004;
  localparam logic [15:0] A_CMD  = 16'h0005;
  localparam logic [15:0] A_WCNT = 16'h0006;
  localparam logic [15:0] A_ECNT = 16'h0007;

  logic        rd_pend;
  logic [31:0] scratch;
  logic [31:0] ctrl;
  logic [14:0] sticky;
  logic        wd_trip;
  logic        wd_fire;
  logic [31:0] wr_cnt;
  logic [15:0] err_cnt;
  logic [31:0] rd_data;
  logic        unmapped;
  logic        wr_scr;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        wr_cmd;
  logic        wr_ecnt;
  logic        wr_bad;
  logic        rd_bad;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign unmapped = (addr > A_ECNT);
  assign wr_scr   = data_mosi_rdy && (addr == A_SCR);
  assign wr_ctrl  = data_mosi_rdy && (addr == A_CTRL);
  assign wr_stat  = data_mosi_rdy && (addr == A_STAT);
  assign wr_cmd   = data_mosi_rdy && (addr == A_CMD);
  assign wr_ecnt  = data_mosi_rdy && (addr == A_ECNT);
  assign wr_bad   = data_mosi_rdy && unmapped;
  assign rd_bad   = rd_pend && unmapped;
  assign err_inc  = {1'b0, wr_bad} + {1'b0, rd_bad};
  assign err_sum  = {1'b0, err_cnt} + {15'd0, err_inc};

  assign ctrl_out = ctrl;

  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    unique case (1'b1)
      addr == A_ID:   rd_data = FPGA_ID;
      addr == A_VER:  rd_data = FPGA_VER;
      addr == A_SCR:  rd_data = scratch;
      addr == A_CTRL: rd_data = ctrl;
      addr == A_STAT: rd_data = {wd_trip, sticky, status_in};
      addr == A_CMD:  rd_data = 32'd0;
      addr == A_WCNT: rd_data = wr_cnt;
      addr == A_ECNT: rd_data = {16'd0, err_cnt};
      default:        rd_data = 32'hDEAD_BEEF;
    endcase
  end

  // addr lags addr_rdy by one cycle, so decode happens on the following cycle
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      data_miso <= 32'd0;
    end else begin
      rd_pend <= addr_rdy;
      if (rd_pend) data_miso <= rd_data;
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      scratch   <= 32'd0;
      ctrl      <= 32'd0;
      cmd_pulse <= 32'd0;
      wr_cnt    <= 32'd0;
    end else begin
      if (wr_scr) scratch <= data_mosi;
      if (wd_fire) ctrl <= 32'd0;
      else if (wr_ctrl) ctrl <= data_mosi;
      cmd_pulse <= wr_cmd ? data_mosi : 32'd0;
      if (data_mosi_rdy) wr_cnt <= wr_cnt + 32'd1;
    end
  end

  // set beats clear: the event term is ORed in after the W1C mask
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      sticky <= 15'd0;
    end else begin
      sticky <= (sticky & ~(wr_stat ? data_mosi[30:16] : 15'd0)) | event_in;
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      err_cnt <= 16'd0;
    end else if (wr_ecnt) begin
      err_cnt <= 16'd0;
    end else begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

`ifdef RCB_REGS_WDOG_EN
  logic [31:0] wd_cnt;
  logic        wd_reload;

  assign wd_reload = data_mosi_rdy && (wr_scr || wr_ctrl || wr_stat || wr_cmd || wr_ecnt);
  assign wd_fire   = !wd_reload && ctrl[31] && (wd_cnt == WDOG_CYCLES - 32'd1);

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      wd_cnt <= 32'd0;
    end else if (wd_reload || !ctrl[31] || wd_fire) begin
      wd_cnt <= 32'd0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      wd_trip <= 1'b0;
    end else if (wd_fire) begin
      wd_trip <= 1'b1;
    end else if (wr_stat && data_mosi[31]) begin
      wd_trip <= 1'b0;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign wd_trip = (WDOG_CYCLES == 32'd0) & 1'b0;
`endif

endmodule

// File: tb/tb_rcb_spi_regs.sv
// tb_rcb_spi_regs: directed plus randomized checks of rcb_spi_regs
// against a transaction-level register model.
module tb_rcb_spi_regs;

  logic        clk_100m = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'd0;
  logic        addr_rdy = 1'b0;
  logic [31:0] data_mosi = 32'd0;
  logic        data_mosi_rdy = 1'b0;
  logic [31:0] data_miso;
  logic [15:0] status_in = 16'd0;
  logic [14:0] event_in = 15'd0;
  logic [31:0] ctrl_out;
  logic [31:0] cmd_pulse;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_scr, m_ctrl, m_wrcnt;
  logic [14:0] m_sticky;
  logic        m_wd;
  int          m_err;

  rcb_spi_regs #(
    .FPGA_ID(32'h5243_4200),
    .FPGA_VER(32'h0000_0100),
    .WDOG_CYCLES(32'd100)
  ) dut (
    .clk_100m(clk_100m),
    .rst(rst),
    .addr(addr),
    .addr_rdy(addr_rdy),
    .data_mosi(data_mosi),
    .data_mosi_rdy(data_mosi_rdy),
    .data_miso(data_miso),
    .status_in(status_in),
    .event_in(event_in),
    .ctrl_out(ctrl_out),
    .cmd_pulse(cmd_pulse)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  function automatic void model_reset();
    m_scr = 0; m_ctrl = 0; m_wrcnt = 0;
    m_sticky = 0; m_wd = 0; m_err = 0;
  endfunction

  function automatic void err_bump();
    if (m_err < 65535) m_err++;
  endfunction

  function automatic void model_wr(input logic [15:0] a, input logic [31:0] d,
                                   input logic [14:0] ev);
    m_wrcnt++;
    case (a)
      16'd2: m_scr = d;
      16'd3: m_ctrl = d;
      16'd4: begin
        m_sticky = m_sticky & ~d[30:16];
        if (d[31]) m_wd = 1'b0;
      end
      16'd7: m_err = 0;
      default: if (a > 16'd7) err_bump();
    endcase
    m_sticky = m_sticky | ev;
  endfunction

  function automatic logic [31:0] model_rd(input logic [15:0] a);
    case (a)
      16'd0: return 32'h5243_4200;
      16'd1: return 32'h0000_0100;
      16'd2: return m_scr;
      16'd3: return m_ctrl;
      16'd4: return {m_wd, m_sticky, status_in};
      16'd5: return 32'd0;
      16'd6: return m_wrcnt;
      16'd7: return m_err;
      default: begin
        err_bump();
        return 32'hDEAD_BEEF;
      end
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [14:0] ev);
    addr = a; data_mosi = d; event_in = ev; data_mosi_rdy = 1'b1;
    tick();
    data_mosi_rdy = 1'b0; event_in = 15'd0;
    model_wr(a, d, ev);
    chk("cmd_pulse", cmd_pulse, (a == 16'd5) ? d : 32'd0);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] q);
    logic [31:0] e;
    status_in = 16'($urandom);
    addr = a; addr_rdy = 1'b1;
    tick();
    addr_rdy = 1'b0;
    e = model_rd(a);
    tick();
    q = data_miso;
    chk("rd_data", q, e);
  endtask

  task automatic idle_ev(input logic [14:0] ev);
    event_in = ev;
    tick();
    event_in = 15'd0;
    m_sticky = m_sticky | ev;
  endtask

  logic [31:0] q;
  logic [31:0] d;
  logic [15:0] a;
  logic [14:0] ev;

  initial begin
    model_reset();
    tick();
    do_reset();
    chk("rst_miso", data_miso, 32'd0);
    chk("rst_ctrl", ctrl_out, 32'd0);
    chk("rst_cmd", cmd_pulse, 32'd0);

    rd(16'h0000, q); chk("id", q, 32'h5243_4200);
    rd(16'h0001, q); chk("ver", q, 32'h0000_0100);

    wr(16'h0002, 32'hA5A5_1234, 15'd0);
    rd(16'h0002, q); chk("scratch", q, 32'hA5A5_1234);
    rd(16'h0006, q); chk("wr_cnt1", q, 32'd1);

    idle_ev(15'h0008);
    rd(16'h0004, q); chk("stk_set", {31'd0, q[19]}, 32'd1);
    wr(16'h0004, 32'h0008_0000, 15'h0008);
    rd(16'h0004, q); chk("stk_win", {31'd0, q[19]}, 32'd1);
    wr(16'h0004, 32'h0008_0000, 15'd0);
    rd(16'h0004, q); chk("stk_clr", {31'd0, q[19]}, 32'd0);

    wr(16'h0005, 32'h0000_0081, 15'd0);
    chk("cmd_on", cmd_pulse, 32'h81);
    tick();
    chk("cmd_off", cmd_pulse, 32'd0);
    wr(16'h0005, 32'h11, 15'd0);
    wr(16'h0005, 32'h22, 15'd0);
    tick();
    chk("cmd_b2b_off", cmd_pulse, 32'd0);
    rd(16'h0005, q); chk("cmd_rd", q, 32'd0);

    rd(16'h1234, q); chk("unmapped", q, 32'hDEAD_BEEF);
    rd(16'h0007, q); chk("err1", q, 32'd1);
    wr(16'h0000, 32'hFFFF_FFFF, 15'd0);
    rd(16'h0007, q); chk("ro_noerr", q, 32'd1);
    rd(16'h0000, q); chk("ro_keep", q, 32'h5243_4200);

    addr = 16'h1234; data_mosi = 32'd0; data_mosi_rdy = 1'b1;
    repeat (65540) @(posedge clk_100m);
    #1;
    data_mosi_rdy = 1'b0;
    m_wrcnt += 65540;
    for (int i = 0; i < 65540; i++) err_bump();
    rd(16'h0007, q); chk("err_sat", q, 32'h0000_FFFF);
    wr(16'h0007, 32'd0, 15'd0);
    rd(16'h0007, q); chk("err_clr", q, 32'd0);

    addr = 16'h0003; data_mosi = 32'h0000_5A5A;
    data_mosi_rdy = 1'b1; addr_rdy = 1'b1;
    tick();
    data_mosi_rdy = 1'b0; addr_rdy = 1'b0;
    model_wr(16'h0003, 32'h0000_5A5A, 15'd0);
    addr = 16'h0002;
    tick();
    chk("both_rd", data_miso, m_scr);
    chk("both_ctrl", ctrl_out, 32'h0000_5A5A);

`ifdef RCB_REGS_WDOG_EN
    wr(16'h0003, 32'h8000_0001, 15'd0);
    repeat (105) tick();
    m_ctrl = 0; m_wd = 1'b1;
    chk("wd_ctrl", ctrl_out, 32'd0);
    rd(16'h0004, q); chk("wd_trip", {31'd0, q[31]}, 32'd1);
    wr(16'h0004, 32'h8000_0000, 15'd0);
    rd(16'h0004, q); chk("wd_w1c", {31'd0, q[31]}, 32'd0);
    wr(16'h0003, 32'h8000_0001, 15'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (49) tick();
      wr(16'h0002, 32'(i), 15'd0);
    end
    chk("wd_kept", ctrl_out, 32'h8000_0001);
    wr(16'h0003, 32'd0, 15'd0);
`else
    wr(16'h0004, 32'h8000_0000, 15'd0);
    rd(16'h0004, q); chk("nowd_b31", {31'd0, q[31]}, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 11);
      a = (r <= 7) ? 16'(r) : 16'($urandom_range(8, 65535));
      d = $urandom;
      if (a == 16'd3) d[31] = 1'b0;
      ev = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'd0;
      case ($urandom_range(0, 2))
        0: wr(a, d, ev);
        1: rd(a, q);
        default: idle_ev(ev);
      endcase
      chk("ctrl_out", ctrl_out, m_ctrl);
    end
    rd(16'h0006, q);
    rd(16'h0004, q);

    wr(16'h0002, 32'h1357_9BDF, 15'd0);
    rd(16'h0002, q);
    addr = 16'h0000; addr_rdy = 1'b1;
    tick();
    addr_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("abort_rst", data_miso, 32'd0);
    repeat (3) tick();
    chk("abort_hold", data_miso, 32'd0);
    rd(16'h0002, q); chk("scr_rst", q, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
